calc_seq_unit: RTL and testbench
================================

# calc_seq_unit

Sequential arithmetic core of the 4-function calculator. It latches two 5-bit operands and an opcode on a start pulse and computes add, subtract, multiply or divide. Multiply and divide are iterative over five cycles. It holds a 5-bit result, which drives the display stage's 5-bit `in` port directly. It also reports completion and overflow/error status.

## Interface

Parameters:
- none (width fixed at 5 bits to match the display stage)

Ports:
- `clk`  input  1  single clock; all state updates on rising edge
- `rst_n`  input  1  asynchronous, active-low reset
- `in0`  input  5  operand A (unsigned), sampled on accepted start
- `in1`  input  5  operand B (unsigned), sampled on accepted start
- `op`  input  2  00 add, 01 sub, 10 mul, 11 div; sampled on accepted start
- `start`  input  1  request; accepted only in IDLE
- `result`  output  5  registered result; feeds display stage
- `busy`  output  1  high while in MUL or DIV state
- `done`  output  1  one-cycle pulse when `result` updates
- `ovf`  output  1  registered; set on add carry-out, sub borrow, mul product > 31, or divide-by-zero

## Operation

- One clock; reset is asynchronous and active-low.
- States: IDLE, MUL, DIV, DONE.
- Reset (`rst_n` = 0, asynchronous): state IDLE; `result` = 0, `ovf` = 0, `done` = 0, `busy` = 0; iteration counter and internal operand/accumulator registers cleared.
- IDLE with `start` = 1: latch `in0`, `in1`, `op`.
  - add: result = (A + B) mod 32, ovf = carry-out; next state DONE.
  - sub: result = (A − B) mod 32, ovf = borrow (A < B); next state DONE.
  - mul: clear accumulator, counter = 0; next state MUL.
  - div with B ≠ 0: clear remainder, counter = 0; next state DIV.
  - div with B = 0: result = 31, ovf = 1; next state DONE.
- MUL: shift-add, one multiplier bit per cycle, LSB first. Accumulator is 10 bits. After the 5th iteration: result = product[4:0], ovf = |product[9:5]; next state DONE.
- DIV: restoring division, one quotient bit per cycle, MSB first, 5-bit remainder. After the 5th iteration: result = quotient, ovf = 0; next state DONE. Remainder is discarded.
- DONE: `done` = 1 for exactly this one cycle; next state IDLE unconditionally. `start` is ignored in DONE.
- `result` and `ovf` change only on entry to DONE (or on reset). They hold between operations so the display stays stable.
- `start` in MUL/DIV/DONE is ignored; no queuing. Input changes after acceptance have no effect.
- Reset mid-operation aborts the operation. No `done` pulse; `result` becomes 0.

## Timing

- Start accepted at edge k (IDLE, `start` = 1).
- add/sub/div-by-zero: state DONE, `result`/`ovf` valid and `done` = 1 in the cycle after edge k+1. 1-cycle latency. Back in IDLE after edge k+2.
- mul/div: `busy` = 1 in the cycles after edges k+1 … k+5. DONE, valid result and `done` = 1 after edge k+6. Next start is accepted at edge k+7 at earliest.
- Maximum throughput: one op per 2 cycles (add/sub) or per 7 cycles (mul/div).
- `busy` and `done` are never high simultaneously.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset: assert `rst_n` = 0 mid-cycle → all outputs 0 immediately. Release, hold `start` = 0 for 10 cycles → outputs stay 0, `done` never pulses.
- Add/sub: 13+9 → `result` = 22, ovf = 0, `done` at cycle k+1. 20+15 → 3, ovf = 1. 5−9 → 28, ovf = 1. 9−5 → 4, ovf = 0.
- Multiply: 6×5 → `busy` for 5 cycles, then `result` = 30, ovf = 0, `done` at k+6. 7×5 → 3, ovf = 1. 31×0 → 0, ovf = 0.
- Divide: 29÷4 → `result` = 7, ovf = 0 at k+6. 3÷7 → 0. 17÷0 → 31, ovf = 1, `done` at k+1, `busy` never asserted.
- Ignored start: start 6×5, pulse `start` with add 1+1 at k+3 → `result` = 30 at k+6. Only one `done` pulse. Result holds 30 until the next accepted start completes.
- Reset mid-op: start 7×4, drop `rst_n` at k+3 → `result` = 0, no `done`. After release, 2+2 → 4.

Source files
------------

// File: rtl/calc_seq_unit.sv
// Sequential arithmetic core of the 4-function calculator: single-cycle add/sub,
// five-cycle shift-add multiply and restoring divide on 5-bit unsigned operands.
module calc_seq_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] in0,
  input  logic [4:0] in1,
  input  logic [1:0] op,
  input  logic       start,
  output logic [4:0] result,
  output logic       busy,
  output logic       done,
  output logic       ovf
);

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e     state_q, state_d;
  logic [4:0] a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
  logic [9:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;

  logic [5:0] add_sum, sub_diff, div_shift;
  logic [9:0] acc_next;
  logic       q_bit;
  logic [4:0] rem_next;

  always_comb begin
    add_sum   = {1'b0, in0} + {1'b0, in1};
    sub_diff  = {1'b0, in0} - {1'b0, in1};
    acc_next  = acc_q + (b_q[0] ? mcand_q : 10'd0);
    // Bring the next dividend bit (MSB first) into the partial remainder.
    div_shift = {rem_q, a_q[4]};
    q_bit     = (div_shift >= {1'b0, b_q});
    // When the trial subtraction succeeds the difference is below the divisor, so 5 bits suffice.
    rem_next  = q_bit ? (div_shift[4:0] - b_q) : div_shift[4:0];
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d = in0;
          b_d = in1;
          unique case (op)
            2'b00: begin
              result_d = add_sum[4:0];
              ovf_d    = add_sum[5];
              state_d  = StDone;
            end
            2'b01: begin
              result_d = sub_diff[4:0];
              ovf_d    = sub_diff[5];
              state_d  = StDone;
            end
            2'b10: begin
              acc_d   = 10'd0;
              mcand_d = {5'd0, in0};
              cnt_d   = 3'd0;
              state_d = StMul;
            end
            default: begin
              if (in1 == 5'd0) begin
                result_d = 5'd31;
                ovf_d    = 1'b1;
                state_d  = StDone;
              end else begin
                rem_d   = 5'd0;
                cnt_d   = 3'd0;
                state_d = StDiv;
              end
            end
          endcase
        end
      end
      StMul: begin
        acc_d   = acc_next;
        mcand_d = mcand_q << 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          result_d = acc_next[4:0];
          ovf_d    = |acc_next[9:5];
          state_d  = StDone;
        end
      end
      StDiv: begin
        rem_d = rem_next;
        a_d   = {a_q[3:0], q_bit};
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd4) begin
          result_d = {a_q[3:0], q_bit};
          ovf_d    = 1'b0;
          state_d  = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= 5'd0;
      b_q      <= 5'd0;
      rem_q    <= 5'd0;
      acc_q    <= 10'd0;
      mcand_q  <= 10'd0;
      cnt_q    <= 3'd0;
      result_q <= 5'd0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == StMul) || (state_q == StDiv);
  assign done   = (state_q == StDone);

endmodule

// File: tb/tb_calc_seq_unit.sv
// Directed and random bench for calc_seq_unit; expected results are queued at
// issue and compared when done pulses.
module tb_calc_seq_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] in0, in1;
  logic [1:0] op;
  logic       start;
  logic [4:0] result;
  logic       busy, done, ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [4:0] res;
    logic       ovf;
    int         lat;
    int         busy_cycles;
  } exp_t;

  exp_t sb[$];

  calc_seq_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in0   (in0),
    .in1   (in1),
    .op    (op),
    .start (start),
    .result(result),
    .busy  (busy),
    .done  (done),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [4:0] a, input logic [4:0] b, input logic [1:0] o);
    exp_t e;
    int   s;
    e.lat = 1;
    e.busy_cycles = 0;
    case (o)
      2'd0: begin
        s = int'(a) + int'(b);
        e.res = 5'(s % 32);
        e.ovf = (s > 31);
      end
      2'd1: begin
        s = int'(a) - int'(b) + 32;
        e.res = 5'(s % 32);
        e.ovf = (a < b);
      end
      2'd2: begin
        s = int'(a) * int'(b);
        e.res = 5'(s % 32);
        e.ovf = (s > 31);
        e.lat = 6;
        e.busy_cycles = 5;
      end
      default: begin
        if (b == 5'd0) begin
          e.res = 5'd31;
          e.ovf = 1'b1;
        end else begin
          e.res = 5'(int'(a) / int'(b));
          e.ovf = 1'b0;
          e.lat = 6;
          e.busy_cycles = 5;
        end
      end
    endcase
    return e;
  endfunction

  task automatic run_op(input string tag, input logic [4:0] a, input logic [4:0] b,
                        input logic [1:0] o, input bit poke);
    exp_t e;
    int   lat;
    int   bcnt;
    bit   overlap;
    bit   seen;
    @(negedge clk);
    in0 = a; in1 = b; op = o; start = 1'b1;
    sb.push_back(model(a, b, o));
    @(negedge clk);
    start = 1'b0;
    in0 = 5'($urandom); in1 = 5'($urandom); op = 2'($urandom);
    lat = 1; bcnt = 0; overlap = 1'b0; seen = 1'b0;
    while (!seen && lat <= 20) begin
      if (busy && done) overlap = 1'b1;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (busy) bcnt++;
        if (poke && lat == 3) begin
          start = 1'b1; in0 = 5'd1; in1 = 5'd1; op = 2'd0;
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        lat++;
      end
    end
    e = sb.pop_front();
    chk({tag, "_latency"}, lat, e.lat);
    chk({tag, "_result"}, {27'd0, result}, {27'd0, e.res});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, e.ovf});
    chk({tag, "_busy_cycles"}, bcnt, e.busy_cycles);
    chk({tag, "_busy_done_overlap"}, {31'd0, overlap}, 0);
    // A start presented while in DONE must be dropped.
    start = 1'b1; in0 = 5'd1; in1 = 5'd1; op = 2'd0;
    @(negedge clk);
    chk({tag, "_single_done"}, {31'd0, done}, 0);
    start = 1'b0;
    @(negedge clk);
    chk({tag, "_hold"}, {27'd0, result}, {27'd0, e.res});
  endtask

  initial begin
    bit pulsed;
    bit stuck;
    rst_n = 1'b1; start = 1'b0; in0 = 5'd0; in1 = 5'd0; op = 2'd0;
    #7 rst_n = 1'b0;
    #1;
    chk("reset_result", {27'd0, result}, 0);
    chk("reset_ovf", {31'd0, ovf}, 0);
    chk("reset_done", {31'd0, done}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulsed = 1'b0; stuck = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) pulsed = 1'b1;
      if (result !== 5'd0 || ovf !== 1'b0 || busy !== 1'b0) stuck = 1'b1;
    end
    chk("idle_no_done", {31'd0, pulsed}, 0);
    chk("idle_outputs_zero", {31'd0, stuck}, 0);

    run_op("add_13_9", 5'd13, 5'd9, 2'd0, 1'b0);
    run_op("add_20_15", 5'd20, 5'd15, 2'd0, 1'b0);
    run_op("sub_5_9", 5'd5, 5'd9, 2'd1, 1'b0);
    run_op("sub_9_5", 5'd9, 5'd5, 2'd1, 1'b0);
    run_op("mul_6_5", 5'd6, 5'd5, 2'd2, 1'b0);
    run_op("mul_7_5", 5'd7, 5'd5, 2'd2, 1'b0);
    run_op("mul_31_0", 5'd31, 5'd0, 2'd2, 1'b0);
    run_op("mul_31_31", 5'd31, 5'd31, 2'd2, 1'b0);
    run_op("div_29_4", 5'd29, 5'd4, 2'd3, 1'b0);
    run_op("div_3_7", 5'd3, 5'd7, 2'd3, 1'b0);
    run_op("div_31_1", 5'd31, 5'd1, 2'd3, 1'b0);
    run_op("div_17_0", 5'd17, 5'd0, 2'd3, 1'b0);
    run_op("mul_6_5_poke", 5'd6, 5'd5, 2'd2, 1'b1);

    pulsed = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (done) pulsed = 1'b1;
    end
    chk("poke_hold_30", {27'd0, result}, 30);
    chk("poke_no_extra_done", {31'd0, pulsed}, 0);

    // Abort a multiply with reset three edges after acceptance.
    @(negedge clk);
    in0 = 5'd7; in1 = 5'd4; op = 2'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_result", {27'd0, result}, 0);
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_done", {31'd0, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulsed = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) pulsed = 1'b1;
    end
    chk("abort_no_done", {31'd0, pulsed}, 0);
    run_op("add_2_2_after_abort", 5'd2, 5'd2, 2'd0, 1'b0);

    for (int i = 0; i < 12; i++) begin
      run_op("random", 5'($urandom), 5'($urandom), 2'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
